ram_arbiter: RTL



---
 rtl/ram_arb_pkg.sv | 7 +
 rtl/ram_arb_pick.sv | 17 +
 rtl/ram_arbiter.sv | 105 ++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared widths, requester id type and FSM states for ram_arbiter.
package ram_arb_pkg;
    localparam int DEF_DATA_W = 1024;
    localparam int DEF_ADDR_W = 5;
    typedef logic req_id_t;
    typedef enum logic {IDLE, ISSUE} state_t;
endpackage

// File: rtl/ram_arb_pick.sv
// ram_arb_pick: combinational 2-way winner select from the eligible bits.
// RAM_ARB_RR_EN defined: round-robin against last; undefined: requester 0 wins ties.
module ram_arb_pick import ram_arb_pkg::*; (
    input  logic [1:0] elig_i,
`ifdef RAM_ARB_RR_EN
    input  req_id_t    last_i,
`endif
    output logic       any_o,
    output req_id_t    win_o
);
    assign any_o = |elig_i;
`ifdef RAM_ARB_RR_EN
    assign win_o = &elig_i ? ~last_i : elig_i[1];
`else
    assign win_o = &elig_i ? 1'b0 : elig_i[1];
`endif
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester arbiter/sequencer in front of a single-port registered-output RAM.
// RAM_ARB_RR_EN selects round-robin tie breaking; otherwise fixed priority to requester 0.
module ram_arbiter import ram_arb_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_write_en,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic [CNT_W-1:0]  contention_cnt
);
    state_t            state_q, state_d;
    req_id_t           id_q, id_d, tag_id_q, tag_id_d;
    logic              tag_v_q, tag_v_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        elig;
    logic              any;
    req_id_t           win;
`ifdef RAM_ARB_RR_EN
    req_id_t           last_q, last_d;
`endif

    assign gnt0           = state_q == ISSUE && id_q == 1'b0;
    assign gnt1           = state_q == ISSUE && id_q == 1'b1;
    assign rvalid0        = tag_v_q && tag_id_q == 1'b0;
    assign rvalid1        = tag_v_q && tag_id_q == 1'b1;
    assign rdata          = tag_v_q ? ram_data_out : '0;
    assign ram_address    = addr_q;
    assign ram_write_en   = we_q;
    assign ram_data_in    = wdata_q;
    assign contention_cnt = cnt_q;
    // A requester still holding req during its own grant cycle is not eligible.
    assign elig           = {req1 & ~gnt1, req0 & ~gnt0};

    ram_arb_pick u_pick (
        .elig_i (elig),
`ifdef RAM_ARB_RR_EN
        .last_i (last_q),
`endif
        .any_o  (any),
        .win_o  (win)
    );

    always_comb begin
        state_d  = any ? ISSUE : IDLE;
        id_d     = any ? win : id_q;
        we_d     = any && (win ? we1 : we0);
        addr_d   = any ? (win ? addr1 : addr0) : addr_q;
        wdata_d  = any ? (win ? wdata1 : wdata0) : wdata_q;
        tag_v_d  = state_q == ISSUE && !we_q;
        tag_id_d = id_q;
        cnt_d    = (&elig && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
`ifdef RAM_ARB_RR_EN
        last_d   = any ? win : last_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            id_q     <= 1'b0;
            tag_v_q  <= 1'b0;
            tag_id_q <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
`ifdef RAM_ARB_RR_EN
            last_q   <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            tag_v_q  <= tag_v_d;
            tag_id_q <= tag_id_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
`ifdef RAM_ARB_RR_EN
            last_q   <= last_d;
`endif
        end
    end
endmodule
